// File: rtl/mem_io_responder_if.sv
// CPU-side byte bus and host-side RX/TX byte streams of mem_io_responder.
// master = CPU/harness side, slave = the responder.
interface mem_io_responder_if;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_ovf;
    logic        halt;

    modport master (
        output rdy_in, mem_a, mem_dout, mem_wr, rx_data, rx_valid, tx_ready,
        input  mem_din, rx_ready, tx_data, tx_valid, tx_ovf, halt
    );

    modport slave (
        input  rdy_in, mem_a, mem_dout, mem_wr, rx_data, rx_valid, tx_ready,
        output mem_din, rx_ready, tx_data, tx_valid, tx_ovf, halt
    );
endinterface

// File: rtl/mem_io_responder.sv
// Byte-wide memory responder: RAM, RX/TX FIFO I/O window, cycle counter and halt flag.
module mem_io_responder #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter              INIT_FILE  = "test.data"
) (
    input logic               clk_in,
    input logic               rst_in,
    mem_io_responder_if.slave bus
);
    localparam int unsigned  IW     = $clog2(FIFO_DEPTH);
    localparam int unsigned  PW     = IW + 1;
    localparam logic [PW-1:0] PtrOne = PW'(1);

    logic [7:0] r_ram [2**ADDR_WIDTH];

    logic [7:0]    r_rx_mem [FIFO_DEPTH];
    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [PW-1:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
    logic [7:0]    r_din;
    logic [31:0]   r_cnt;
    logic [31:0]   r_snap;
    logic          r_ovf;
    logic          r_halt;

    logic [17:0]           w_a;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic                  w_acc, w_is_io, w_is_ram;
    logic                  w_sel_data, w_sel_cnt, w_sel_halt;
    logic                  w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic                  w_rx_push, w_rx_pop, w_tx_push_req, w_tx_push, w_tx_pop;
    logic [7:0]            w_tx_byte;
    logic [7:0]            w_din_next;
    logic                  w_unused;

    // Address decode; only bits [17:0] matter.
    assign w_a        = bus.mem_a[17:0];
    assign w_ram_addr = w_a[ADDR_WIDTH-1:0];
    assign w_acc      = bus.rdy_in && !rst_in;
    assign w_is_io    = (w_a[17:16] == 2'b11);
    assign w_is_ram   = ((w_a >> ADDR_WIDTH) == 18'd0);
    assign w_sel_data = w_is_io && (w_a == 18'h30000);
    assign w_sel_cnt  = w_is_io && (w_a[17:2] == 16'hC001);
    assign w_sel_halt = w_is_io && (w_a == 18'h30004);

    // Pointer MSB distinguishes a full FIFO from an empty one.
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[PW-1] != r_rx_rp[PW-1]) &&
                        (r_rx_wp[PW-2:0] == r_rx_rp[PW-2:0]);
    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[PW-1] != r_tx_rp[PW-1]) &&
                        (r_tx_wp[PW-2:0] == r_tx_rp[PW-2:0]);

    assign w_rx_push = bus.rx_valid && !w_rx_full;
    assign w_rx_pop  = w_acc && !bus.mem_wr && w_sel_data && !w_rx_empty;
    assign w_tx_pop  = !w_tx_empty && bus.tx_ready;

    // Halt writes push a zero, bypassing the zero filter of the data port.
    assign w_tx_push_req = w_acc && bus.mem_wr &&
                           ((w_sel_data && (bus.mem_dout != 8'h00)) || w_sel_halt);
    assign w_tx_push     = w_tx_push_req && !w_tx_full;
    assign w_tx_byte     = w_sel_halt ? 8'h00 : bus.mem_dout;

    always_comb begin
        w_din_next = r_din;
        if (w_acc && !bus.mem_wr) begin
            if (w_is_ram) begin
                w_din_next = r_ram[w_ram_addr];
            end else if (w_sel_data) begin
                w_din_next = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp[IW-1:0]];
            end else if (w_sel_cnt) begin
                // Byte 0 comes straight from the counter as snap is loaded with it.
                case (w_a[1:0])
                    2'd0:    w_din_next = r_cnt[7:0];
                    2'd1:    w_din_next = r_snap[15:8];
                    2'd2:    w_din_next = r_snap[23:16];
                    default: w_din_next = r_snap[31:24];
                endcase
            end else begin
                w_din_next = 8'h00;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_acc && bus.mem_wr && w_is_ram) begin
            r_ram[w_ram_addr] <= bus.mem_dout;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wp[IW-1:0]] <= bus.rx_data;
        end
        if (w_tx_push) begin
            r_tx_mem[r_tx_wp[IW-1:0]] <= w_tx_byte;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_din   <= 8'h00;
            r_cnt   <= 32'd0;
            r_snap  <= 32'd0;
            r_rx_wp <= '0;
            r_rx_rp <= '0;
            r_tx_wp <= '0;
            r_tx_rp <= '0;
            r_ovf   <= 1'b0;
            r_halt  <= 1'b0;
        end else begin
            r_din <= w_din_next;
            r_cnt <= r_cnt + 32'd1;
            if (w_acc && !bus.mem_wr && w_sel_cnt && (w_a[1:0] == 2'd0)) begin
                r_snap <= r_cnt;
            end
            if (w_rx_push) begin
                r_rx_wp <= r_rx_wp + PtrOne;
            end
            if (w_rx_pop) begin
                r_rx_rp <= r_rx_rp + PtrOne;
            end
            if (w_tx_push) begin
                r_tx_wp <= r_tx_wp + PtrOne;
            end
            if (w_tx_pop) begin
                r_tx_rp <= r_tx_rp + PtrOne;
            end
            if (w_tx_push_req && w_tx_full) begin
                r_ovf <= 1'b1;
            end
            if (w_acc && bus.mem_wr && w_sel_halt) begin
                r_halt <= 1'b1;
            end
        end
    end

    assign bus.mem_din  = r_din;
    assign bus.rx_ready = !w_rx_full;
    assign bus.tx_valid = !w_tx_empty;
    assign bus.tx_data  = r_tx_mem[r_tx_rp[IW-1:0]];
    assign bus.tx_ovf   = r_ovf;
    assign bus.halt     = r_halt;

    assign w_unused = ^{bus.mem_a[31:18], r_snap[7:0]} ^ (^INIT_FILE);
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with a queue-based reference model checked every cycle.
module tb_mem_io_responder;
    localparam int unsigned AW    = 17;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fails  = 0;

    mem_io_responder_if bus_if ();

    mem_io_responder #(
        .ADDR_WIDTH(AW),
        .FIFO_DEPTH(DEPTH),
        .INIT_FILE ("test.data")
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: RAM as a sparse map, FIFOs as queues.
    logic [7:0]  m_ram [int];
    logic [7:0]  m_rxq [$];
    logic [7:0]  m_txq [$];
    logic [31:0] m_cnt, m_snap;
    logic [7:0]  m_din;
    bit          m_din_known, m_ovf, m_halt;
    bit          m_on = 0;

    always @(posedge clk) begin : model
        int  a;
        bit  rx_pre_full, rx_pre_nonempty, tx_pre_full, tx_pop, push;
        logic [7:0] pushv;
        if (rst) begin
            m_cnt = 0; m_snap = 0; m_din = 8'h00; m_din_known = 1;
            m_ovf = 0; m_halt = 0; m_on = 1;
            m_rxq.delete(); m_txq.delete();
        end else begin
            rx_pre_full     = (m_rxq.size() == DEPTH);
            rx_pre_nonempty = (m_rxq.size() > 0);
            tx_pre_full     = (m_txq.size() == DEPTH);
            tx_pop          = (m_txq.size() > 0) && bus_if.tx_ready;
            push  = 0;
            pushv = 8'h00;
            a     = int'(bus_if.mem_a[17:0]);
            if (bus_if.rdy_in) begin
                if (bus_if.mem_wr) begin
                    m_din_known = 0;
                    if (a < (1 << AW)) begin
                        m_ram[a] = bus_if.mem_dout;
                    end else if (a == 'h30000 && bus_if.mem_dout != 8'h00) begin
                        push = 1; pushv = bus_if.mem_dout;
                    end else if (a == 'h30004) begin
                        push = 1; pushv = 8'h00; m_halt = 1;
                    end
                end else begin
                    m_din_known = 1;
                    if (a < (1 << AW)) begin
                        if (m_ram.exists(a)) m_din = m_ram[a];
                        else m_din_known = 0;
                    end else if (a == 'h30000) begin
                        m_din = rx_pre_nonempty ? m_rxq.pop_front() : 8'h00;
                    end else if (a == 'h30004) begin
                        m_snap = m_cnt;
                        m_din  = m_cnt[7:0];
                    end else if (a >= 'h30005 && a <= 'h30007) begin
                        m_din = 8'(m_snap >> (8 * (a - 'h30004)));
                    end else begin
                        m_din = 8'h00;
                    end
                end
            end
            if (bus_if.rx_valid && !rx_pre_full) m_rxq.push_back(bus_if.rx_data);
            if (tx_pop) void'(m_txq.pop_front());
            if (push) begin
                if (tx_pre_full) m_ovf = 1;
                else m_txq.push_back(pushv);
            end
            m_cnt = m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            if (m_din_known) check("cmp_mem_din", bus_if.mem_din, m_din);
            check("cmp_tx_valid", bus_if.tx_valid, m_txq.size() > 0);
            if (m_txq.size() > 0) check("cmp_tx_data", bus_if.tx_data, m_txq[0]);
            check("cmp_rx_ready", bus_if.rx_ready, m_rxq.size() < DEPTH);
            check("cmp_tx_ovf", bus_if.tx_ovf, m_ovf);
            check("cmp_halt", bus_if.halt, m_halt);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog expired");
    end

    task automatic bus_op(input logic rdy, input logic [31:0] a, input logic wr,
                          input logic [7:0] d);
        bus_if.rdy_in   = rdy;
        bus_if.mem_a    = a;
        bus_if.mem_wr   = wr;
        bus_if.mem_dout = d;
        @(posedge clk); #1;
        bus_if.rdy_in = 1'b0;
        bus_if.mem_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic rx_push(input logic [7:0] d);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = d;
        @(posedge clk); #1;
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic read_snap(output logic [31:0] v);
        for (int k = 0; k < 4; k++) begin
            bus_op(1'b1, 32'h30004 + 32'(k), 1'b0, 8'h00);
            v[8*k +: 8] = bus_if.mem_din;
        end
    endtask

    initial begin
        logic [31:0] snap;
        logic [7:0]  exp;
        bus_if.rdy_in = 0; bus_if.mem_a = 0; bus_if.mem_dout = 0; bus_if.mem_wr = 0;
        bus_if.rx_data = 0; bus_if.rx_valid = 0; bus_if.tx_ready = 0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        check("reset_mem_din", bus_if.mem_din, 8'h00);
        check("reset_tx_valid", bus_if.tx_valid, 1'b0);
        check("reset_rx_ready", bus_if.rx_ready, 1'b1);
        check("reset_halt", bus_if.halt, 1'b0);
        check("reset_tx_ovf", bus_if.tx_ovf, 1'b0);

        bus_op(1'b1, 32'h00010, 1'b1, 8'hA5);
        bus_op(1'b1, 32'h00010, 1'b0, 8'h00);
        check("ram_write_read", bus_if.mem_din, 8'hA5);
        bus_op(1'b1, 32'h20000, 1'b0, 8'h00);
        check("hole_read", bus_if.mem_din, 8'h00);
        bus_op(1'b1, 32'h20010, 1'b1, 8'h99);
        bus_op(1'b1, 32'hFFFC0010, 1'b0, 8'h00);
        check("hole_write_ignored", bus_if.mem_din, 8'hA5);

        rx_push(8'h41);
        rx_push(8'h42);
        bus_op(1'b1, 32'h30000, 1'b0, 8'h00);
        check("rx_pop0", bus_if.mem_din, 8'h41);
        bus_op(1'b1, 32'h30000, 1'b0, 8'h00);
        check("rx_pop1", bus_if.mem_din, 8'h42);
        bus_op(1'b1, 32'h30000, 1'b0, 8'h00);
        check("rx_empty_read", bus_if.mem_din, 8'h00);

        bus_if.tx_ready = 1'b0;
        bus_op(1'b1, 32'h30000, 1'b1, 8'h00);
        check("tx_zero_filtered", bus_if.tx_valid, 1'b0);
        bus_op(1'b1, 32'h30000, 1'b1, 8'h7A);
        check("tx_head_7a", bus_if.tx_data, 8'h7A);
        for (int i = 0; i < DEPTH; i++) begin
            bus_op(1'b1, 32'h30000, 1'b1, 8'h80 + 8'(i));
            if (i == DEPTH - 2) check("tx_ovf_before_full", bus_if.tx_ovf, 1'b0);
        end
        check("tx_ovf_after_drop", bus_if.tx_ovf, 1'b1);
        bus_if.tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp = (i == 0) ? 8'h7A : 8'h80 + 8'(i - 1);
            check("tx_drain_valid", bus_if.tx_valid, 1'b1);
            check("tx_drain_data", bus_if.tx_data, exp);
            @(posedge clk); #1;
        end
        check("tx_drained", bus_if.tx_valid, 1'b0);
        bus_if.tx_ready = 1'b0;

        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("rst_clears_ovf", bus_if.tx_ovf, 1'b0);
        idle(100);
        read_snap(snap);
        check("snap_100", snap, 32'd100);

        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        idle(511);
        read_snap(snap);
        check("snap_1ff_coherent", snap, 32'h000001FF);

        bus_op(1'b1, 32'h00020, 1'b1, 8'h33);
        bus_op(1'b0, 32'h00020, 1'b1, 8'h55);
        bus_op(1'b1, 32'h00020, 1'b0, 8'h00);
        check("rdy_low_no_write", bus_if.mem_din, 8'h33);
        rx_push(8'h5C);
        bus_op(1'b0, 32'h30000, 1'b0, 8'h00);
        check("rdy_low_din_hold", bus_if.mem_din, 8'h33);
        bus_op(1'b1, 32'h30000, 1'b0, 8'h00);
        check("rdy_low_no_pop", bus_if.mem_din, 8'h5C);
        check("halt_before", bus_if.halt, 1'b0);
        bus_op(1'b1, 32'h30004, 1'b1, 8'hFF);
        check("halt_set", bus_if.halt, 1'b1);
        check("halt_tx_valid", bus_if.tx_valid, 1'b1);
        check("halt_tx_zero", bus_if.tx_data, 8'h00);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
